btn_event_fsm: RTL and testbench
================================

Name: btn_event_fsm

Overview:
- Consumes the debounced push-button level from the debounce stage and turns it into single-cycle event pulses for the lab control logic (stopwatch start/stop, counter step).
- Events: press, short release, long press and auto-repeat while held, plus a held-level flag.
- All outputs are registered and synchronous to clk_100.

Parameters:
- LONG_CYCLES, 100_000_000, number of high samples (press edge included) that qualify a long press; must be >= 2.
- REPEAT_CYCLES, 20_000_000, period in cycles of repeat_pulse after a long press; must be >= 1.
- REPEAT_EN, 1, enables repeat_pulse: 1 = repeats on, 0 = no repeats.

Ports:
- clk_100  input  1  100 MHz system clock.
- rst  input  1  asynchronous, active-high reset.
- pb_de  input  1  debounced button level, already synchronous to clk_100.
- press_pulse  output  1  one cycle on each accepted press.
- short_pulse  output  1  one cycle on a release before the long threshold.
- long_pulse  output  1  one cycle when the hold reaches LONG_CYCLES.
- repeat_pulse  output  1  one cycle every REPEAT_CYCLES while held after a long press.
- release_pulse  output  1  one cycle on any release of an accepted press.
- held  output  1  high while in state HOLD.

Behaviour:
- Reset behaviour (asynchronous, active-high, on rst on clock clk_100):
  - All outputs reset to 0, state resets to IDLE and cnt resets to 0.
  - pb_prev resets to 1, so a button held through reset generates no event. pb_de must be sampled 0 at least once before a press is accepted.
- pb_prev is pb_de registered every edge. Rise condition: pb_de=1 and pb_prev=0.
- States: IDLE, PRESS, HOLD (2-bit encoding).
- IDLE: on rise at edge t0, go to PRESS with cnt<=1 and press_pulse=1 during the following cycle. Otherwise stay.
- PRESS, on each edge:
  - pb_de=0: short_pulse=1 and release_pulse=1 (same cycle), go to IDLE, cnt<=0.
  - pb_de=1 and cnt==LONG_CYCLES-1: long_pulse=1, go to HOLD, cnt<=0. long_pulse is therefore LONG_CYCLES-1 cycles after press_pulse.
  - Otherwise cnt<=cnt+1.
- HOLD, on each edge:
  - pb_de=0: release_pulse=1, go to IDLE, cnt<=0. No short_pulse.
  - pb_de=1 and REPEAT_EN=1 and cnt==REPEAT_CYCLES-1: repeat_pulse=1, cnt<=0. The first repeat is REPEAT_CYCLES cycles after long_pulse, then every REPEAT_CYCLES cycles.
  - Otherwise cnt<=cnt+1, saturating at REPEAT_CYCLES-1 when REPEAT_EN=0.
- held is registered: 1 in the cycle long_pulse is high and thereafter while in HOLD; 0 from the cycle release_pulse is high.
- Pulses:
  - Every pulse is exactly one cycle wide.
  - press, long, short and repeat are mutually exclusive in any cycle.
  - release_pulse coincides only with short_pulse.
- Counter width: CNT_W = $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1). No wrap is possible because the compares are exact and cnt resets on a match.
- Release and re-press: a release followed by pb_de=1 on the next edge is a new rise from IDLE and is accepted normally.
- Reset mid-operation (PRESS or HOLD): outputs drop asynchronously, no release_pulse is produced, and a fresh low level is required before the next press.

Decomposition:
- Shared package btn_pkg: state localparams (ST_IDLE=2'd0, ST_PRESS=2'd1, ST_HOLD=2'd2) and the CNT_W width function.
- One sub-module, btn_hold_timer: a loadable, clearable cycle counter with a terminal-count compare input. The FSM and output registers stay in btn_event_fsm.

Test Plan:
All scenarios use LONG_CYCLES=10, REPEAT_CYCLES=4, REPEAT_EN=1.
- Short press: pb_de 0→1 for 5 cycles, then 0 → press_pulse 1 cycle after the rise, then short_pulse and release_pulse in the same cycle after the fall. No long_pulse; held stays 0.
- Long press with repeats: pb_de high for 25 cycles → press at cycle 1, long_pulse 9 cycles later with held=1, repeat_pulse at +4, +8 and +12 after long_pulse. On the fall: release_pulse, no short_pulse, held=0.
- Boundary: pb_de high for exactly 9 cycles gives short_pulse and no long. High for exactly 10 cycles gives long_pulse and a HOLD release with no short_pulse.
- Held through reset: pb_de=1 while rst pulses → no press_pulse. After pb_de goes 0 then 1, press_pulse is asserted once.
- Reset mid-HOLD: assert rst 2 cycles after long_pulse → all outputs 0 immediately, no release_pulse. The state reads IDLE after deassertion.
- REPEAT_EN=0 with a 30-cycle hold → long_pulse once, no repeat_pulse, release_pulse on the fall.

Source files
------------

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared definitions for the push-button event logic.
//               - State encodings for the event FSM (IDLE / PRESS / HOLD).
//               - cnt_width(): hold-timer width able to hold
//                 max(LONG_CYCLES, REPEAT_CYCLES).
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Width needed to represent max(long_c, rep_c). The compares in the FSM
    // are exact and the counter is cleared on every match, so it never wraps.
    function automatic int cnt_width(input int long_c, input int rep_c);
        int m;
        m = (long_c > rep_c) ? long_c : rep_c;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : btn_hold_timer
// Description : Loadable, clearable cycle counter with terminal-count compare.
//               Priority: clr > load > inc. tc is a combinational equality
//               flag of the current count against tc_val.
// Ports       : clk_100  - system clock
//               rst      - asynchronous active-high reset (count -> 0)
//               clr      - synchronous clear to 0
//               load     - synchronous load of load_val
//               inc      - increment by one
//               load_val - value loaded when load is high
//               tc_val   - terminal-count compare value
//               tc       - high while count == tc_val
// Revision    : 1.0 - initial release
// ============================================================================
module btn_hold_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_100,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tc = (r_cnt == tc_val);

endmodule
`default_nettype wire

// File: rtl/btn_event_fsm.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_fsm
// Description : Turns the debounced push-button level into single-cycle
//               event pulses: press, short release, long press, auto-repeat
//               while held, any release, plus a held-level flag.
//               All outputs are registered.
// Ports       : clk_100       - 100 MHz system clock
//               rst           - asynchronous active-high reset
//               pb_de         - debounced button level (clk_100 domain)
//               press_pulse   - one cycle on each accepted press
//               short_pulse   - one cycle on release before long threshold
//               long_pulse    - one cycle when hold reaches LONG_CYCLES
//               repeat_pulse  - one cycle every REPEAT_CYCLES after long
//               release_pulse - one cycle on any release of accepted press
//               held          - high while in HOLD
// Revision    : 1.0 - initial release
// ============================================================================
module btn_event_fsm
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk_100,
    input  logic rst,
    input  logic pb_de,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    localparam int               CNT_W     = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] C_LONG_TC = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_pb_prev;

    logic             w_clr;
    logic             w_load;
    logic             w_inc;
    logic [CNT_W-1:0] w_tc_val;
    logic             w_tc;

    logic             r_press, r_short, r_long, r_repeat, r_release, r_held;
    logic             w_press_nxt, w_short_nxt, w_long_nxt, w_repeat_nxt;
    logic             w_release_nxt, w_held_nxt;

    // pb_prev resets high so a button held through reset produces no rise:
    // a low sample must be seen before the next press is accepted.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_pb_prev <= 1'b1;
        end else begin
            r_pb_prev <= pb_de;
        end
    end

    btn_hold_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_100  (clk_100),
        .rst      (rst),
        .clr      (w_clr),
        .load     (w_load),
        .inc      (w_inc),
        .load_val (C_ONE),
        .tc_val   (w_tc_val),
        .tc       (w_tc)
    );

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_press   <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_release <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_press   <= w_press_nxt;
            r_short   <= w_short_nxt;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
            r_release <= w_release_nxt;
            r_held    <= w_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr         = 1'b0;
        w_load        = 1'b0;
        w_inc         = 1'b0;
        w_tc_val      = C_LONG_TC;
        w_press_nxt   = 1'b0;
        w_short_nxt   = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_release_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The rising sample itself counts as the first high sample.
                if (pb_de && !r_pb_prev) begin
                    w_state_nxt = ST_PRESS;
                    w_load      = 1'b1;
                    w_press_nxt = 1'b1;
                end
            end

            ST_PRESS: begin
                w_tc_val = C_LONG_TC;
                if (!pb_de) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr         = 1'b1;
                    w_short_nxt   = 1'b1;
                    w_release_nxt = 1'b1;
                end else if (w_tc) begin
                    w_state_nxt = ST_HOLD;
                    w_clr       = 1'b1;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_inc = 1'b1;
                end
            end

            ST_HOLD: begin
                w_tc_val = C_REP_TC;
                if (!pb_de) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr         = 1'b1;
                    w_release_nxt = 1'b1;
                end else if (w_tc) begin
                    // With repeats disabled the count parks at the terminal
                    // value instead of restarting.
                    if (REPEAT_EN) begin
                        w_clr        = 1'b1;
                        w_repeat_nxt = 1'b1;
                    end
                end else begin
                    w_inc = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_clr       = 1'b1;
            end
        endcase

        w_held_nxt = (w_state_nxt == ST_HOLD);
    end

    assign press_pulse   = r_press;
    assign short_pulse   = r_short;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_repeat;
    assign release_pulse = r_release;
    assign held          = r_held;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_fsm
// Description : Directed self-checking bench for btn_event_fsm.
//               dut_a: LONG=10, REPEAT=4, REPEAT_EN=1
//               dut_b: LONG=10, REPEAT=4, REPEAT_EN=0
//               Output vectors are {press,short,long,repeat,release,held}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_fsm;

    localparam logic [5:0] P = 6'b100000;
    localparam logic [5:0] S = 6'b010000;
    localparam logic [5:0] L = 6'b001000;
    localparam logic [5:0] R = 6'b000100;
    localparam logic [5:0] X = 6'b000010;
    localparam logic [5:0] H = 6'b000001;
    localparam logic [5:0] Z = 6'b000000;

    logic clk_100 = 1'b0;
    logic rst;
    logic pb_a;
    logic pb_b;

    logic a_press, a_short, a_long, a_rep, a_rel, a_held;
    logic b_press, b_short, b_long, b_rep, b_rel, b_held;
    logic [5:0] w_a;
    logic [5:0] w_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_100 = ~clk_100;

    btn_event_fsm #(
        .LONG_CYCLES   (10),
        .REPEAT_CYCLES (4),
        .REPEAT_EN     (1'b1)
    ) dut_a (
        .clk_100       (clk_100),
        .rst           (rst),
        .pb_de         (pb_a),
        .press_pulse   (a_press),
        .short_pulse   (a_short),
        .long_pulse    (a_long),
        .repeat_pulse  (a_rep),
        .release_pulse (a_rel),
        .held          (a_held)
    );

    btn_event_fsm #(
        .LONG_CYCLES   (10),
        .REPEAT_CYCLES (4),
        .REPEAT_EN     (1'b0)
    ) dut_b (
        .clk_100       (clk_100),
        .rst           (rst),
        .pb_de         (pb_b),
        .press_pulse   (b_press),
        .short_pulse   (b_short),
        .long_pulse    (b_long),
        .repeat_pulse  (b_rep),
        .release_pulse (b_rel),
        .held          (b_held)
    );

    assign w_a = {a_press, a_short, a_long, a_rep, a_rel, a_held};
    assign w_b = {b_press, b_short, b_long, b_rep, b_rel, b_held};

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive levels for the next rising edge, then check the registered
    // outputs on the following falling edge.
    task automatic cyc(input string tag, input logic a, input logic b,
                       input logic [5:0] ea, input logic [5:0] eb);
        pb_a = a;
        pb_b = b;
        @(posedge clk_100);
        @(negedge clk_100);
        chk({tag, "/a"}, w_a, ea);
        chk({tag, "/b"}, w_b, eb);
    endtask

    initial begin
        logic [5:0] e;

        rst  = 1'b1;
        pb_a = 1'b0;
        pb_b = 1'b0;
        repeat (2) @(negedge clk_100);
        chk("reset/a", w_a, Z);
        chk("reset/b", w_b, Z);
        chk("reset_state", {4'b0, dut_a.r_state}, Z);
        rst = 1'b0;
        cyc("idle0", 1'b0, 1'b0, Z, Z);
        cyc("idle1", 1'b0, 1'b0, Z, Z);

        // Short press: 5 high samples then low.
        cyc("short1", 1'b1, 1'b0, P, Z);
        for (int i = 2; i <= 5; i++) cyc($sformatf("short%0d", i), 1'b1, 1'b0, Z, Z);
        cyc("short_rel", 1'b0, 1'b0, S | X, Z);
        cyc("short_after", 1'b0, 1'b0, Z, Z);

        // Long press with repeats: 25 high samples.
        for (int i = 1; i <= 25; i++) begin
            if (i == 1)                           e = P;
            else if (i < 10)                      e = Z;
            else if (i == 10)                     e = L | H;
            else if (((i - 10) % 4) == 0)         e = R | H;
            else                                  e = H;
            cyc($sformatf("long%0d", i), 1'b1, 1'b0, e, Z);
        end
        cyc("long_rel", 1'b0, 1'b0, X, Z);
        cyc("long_after", 1'b0, 1'b0, Z, Z);

        // Boundary: 9 high samples is still short.
        for (int i = 1; i <= 9; i++)
            cyc($sformatf("b9_%0d", i), 1'b1, 1'b0, (i == 1) ? P : Z, Z);
        cyc("b9_rel", 1'b0, 1'b0, S | X, Z);

        // Boundary: 10 high samples reaches long.
        for (int i = 1; i <= 10; i++)
            cyc($sformatf("b10_%0d", i), 1'b1, 1'b0,
                (i == 1) ? P : ((i == 10) ? (L | H) : Z), Z);
        cyc("b10_rel", 1'b0, 1'b0, X, Z);

        // Release and immediate re-press is a fresh rise.
        cyc("repress", 1'b1, 1'b0, P, Z);
        cyc("repress_rel", 1'b0, 1'b0, S | X, Z);
        cyc("repress_idle", 1'b0, 1'b0, Z, Z);

        // Held through reset: no press until a low level is seen.
        pb_a = 1'b1;
        rst  = 1'b1;
        #1;
        chk("hr_rst", w_a, Z);
        @(negedge clk_100);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("hr_hold%0d", i), 1'b1, 1'b0, Z, Z);
        cyc("hr_low", 1'b0, 1'b0, Z, Z);
        cyc("hr_press", 1'b1, 1'b0, P, Z);
        cyc("hr_hold", 1'b1, 1'b0, Z, Z);
        cyc("hr_rel", 1'b0, 1'b0, S | X, Z);
        cyc("hr_idle", 1'b0, 1'b0, Z, Z);

        // Reset two cycles after long_pulse.
        for (int i = 1; i <= 12; i++) begin
            if (i == 1)       e = P;
            else if (i < 10)  e = Z;
            else if (i == 10) e = L | H;
            else              e = H;
            cyc($sformatf("mh%0d", i), 1'b1, 1'b0, e, Z);
        end
        rst = 1'b1;
        #1;
        chk("mh_rst_out", w_a, Z);
        chk("mh_rst_state", {4'b0, dut_a.r_state}, Z);
        @(negedge clk_100);
        rst = 1'b0;
        #1;
        chk("mh_state_after", {4'b0, dut_a.r_state}, Z);
        cyc("mh_post0", 1'b1, 1'b0, Z, Z);
        cyc("mh_post1", 1'b1, 1'b0, Z, Z);
        cyc("mh_post_low", 1'b0, 1'b0, Z, Z);

        // REPEAT_EN=0: 30-cycle hold, long once, no repeats.
        for (int i = 1; i <= 30; i++) begin
            if (i == 1)       e = P;
            else if (i < 10)  e = Z;
            else if (i == 10) e = L | H;
            else              e = H;
            cyc($sformatf("nr%0d", i), 1'b0, 1'b1, Z, e);
        end
        cyc("nr_rel", 1'b0, 1'b0, Z, X);
        cyc("nr_after", 1'b0, 1'b0, Z, Z);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
